// File: rtl/dp_sched_pkg.sv
// dp_sched_pkg: shared definitions for the dp_sched slice sequencer.
//   DP_MAX_N_SPLIT : default upper bound on splits per job
//   DP_TIMEOUT_W   : default watchdog counter width
//   dp_state_t     : sequencer state encoding
package dp_sched_pkg;

  localparam int unsigned DP_MAX_N_SPLIT = 4;
  localparam int unsigned DP_TIMEOUT_W   = 16;

  typedef enum logic [2:0] {
    DP_S_IDLE,
    DP_S_NTT_GO,
    DP_S_NTT_WAIT,
    DP_S_MADD_GO,
    DP_S_MADD_WAIT,
    DP_S_DONE
  } dp_state_t;

endpackage

// File: rtl/dp_sched_if.sv
// dp_sched_if: control and dp_core handshake bundle of the sequencer.
//   i_start / i_num_split / i_abort : job control from the top-level controller
//   o_ntt_start / i_ntt_done        : NTT pulse and completion level (dp_core)
//   o_madd_start / i_madd_done      : MADD pulse and completion level (dp_core)
//   o_idx_split                     : current split index to dp_core
//   o_busy / o_done / o_err         : status back to the top-level controller
// master: controller/dp_core side; slave: dp_sched.
interface dp_sched_if #(
  parameter int unsigned SPLIT_W = 2
);

  logic               i_start;
  logic [SPLIT_W-1:0] i_num_split;
  logic               i_abort;
  logic               o_ntt_start;
  logic               i_ntt_done;
  logic               o_madd_start;
  logic               i_madd_done;
  logic [SPLIT_W-1:0] o_idx_split;
  logic               o_busy;
  logic               o_done;
  logic               o_err;

  modport master (
    output i_start, i_num_split, i_abort, i_ntt_done, i_madd_done,
    input  o_ntt_start, o_madd_start, o_idx_split, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_num_split, i_abort, i_ntt_done, i_madd_done,
    output o_ntt_start, o_madd_start, o_idx_split, o_busy, o_done, o_err
  );

endinterface

// File: rtl/dp_sched_edge_det.sv
// dp_edge_det: 1-bit rising-edge detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : level input
//   rise       : d high now and low in the previous cycle
module dp_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/dp_sched.sv
// dp_sched: per-split NTT -> MADD sequencer for one dp_core slice.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dp_sched_if slave (job control, dp_core pulses/done levels,
//                split index, busy/done/err status)
// One start runs splits 0..i_num_split; each wait state is guarded by a
// watchdog that raises a sticky error and returns to IDLE.
module dp_sched
  import dp_sched_pkg::*;
#(
  parameter int unsigned MAX_N_SPLIT = DP_MAX_N_SPLIT,
  parameter int unsigned SPLIT_W     = 2,
  parameter int unsigned TIMEOUT_W   = DP_TIMEOUT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  dp_sched_if.slave  bus
);

  localparam logic [SPLIT_W-1:0]   SPLIT_LAST_MAX = SPLIT_W'(MAX_N_SPLIT - 1);
  // Counter starts at 0 on the entry cycle, so expiring one short of all-ones
  // makes the error visible exactly 2^TIMEOUT_W-1 cycles after entry.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  dp_state_t            state, state_nxt;
  logic [SPLIT_W-1:0]   idx, idx_nxt, num_split_r;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 ntt_rise, madd_rise;
  logic                 in_wait, wd_last, last_split, start_acc, timeout_hit;
  logic                 ntt_start_d, madd_start_d, busy_d, done_d, err_d;

  dp_edge_det u_ntt_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.i_ntt_done),
    .rise (ntt_rise)
  );

  dp_edge_det u_madd_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.i_madd_done),
    .rise (madd_rise)
  );

  assign in_wait     = (state == DP_S_NTT_WAIT) || (state == DP_S_MADD_WAIT);
  assign wd_last     = (wd_cnt == WD_LAST);
  assign last_split  = (idx == num_split_r);
  assign start_acc   = (state == DP_S_IDLE) && bus.i_start && !bus.i_abort;
  // A done edge in the expiry cycle wins over the timeout.
  assign timeout_hit = !bus.i_abort && wd_last &&
                       (((state == DP_S_NTT_WAIT)  && !ntt_rise) ||
                        ((state == DP_S_MADD_WAIT) && !madd_rise));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DP_S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.i_abort) begin
      state_nxt = DP_S_IDLE;
    end else begin
      case (state)
        DP_S_IDLE:      if (bus.i_start) state_nxt = DP_S_NTT_GO;
        DP_S_NTT_GO:    state_nxt = DP_S_NTT_WAIT;
        DP_S_NTT_WAIT: begin
          if (ntt_rise)     state_nxt = DP_S_MADD_GO;
          else if (wd_last) state_nxt = DP_S_IDLE;
        end
        DP_S_MADD_GO:   state_nxt = DP_S_MADD_WAIT;
        DP_S_MADD_WAIT: begin
          if (madd_rise)    state_nxt = last_split ? DP_S_DONE : DP_S_NTT_GO;
          else if (wd_last) state_nxt = DP_S_IDLE;
        end
        DP_S_DONE:      state_nxt = DP_S_IDLE;
        default:        state_nxt = DP_S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they belong to.
  always_comb begin
    ntt_start_d  = (state_nxt == DP_S_NTT_GO);
    madd_start_d = (state_nxt == DP_S_MADD_GO);
    busy_d       = (state_nxt != DP_S_IDLE);
    done_d       = (state_nxt == DP_S_DONE);

    err_d = bus.o_err;
    if (start_acc)        err_d = 1'b0;
    else if (timeout_hit) err_d = 1'b1;

    idx_nxt = idx;
    if (start_acc)
      idx_nxt = '0;
    else if (!bus.i_abort && (state == DP_S_MADD_WAIT) && madd_rise && !last_split)
      idx_nxt = idx + SPLIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx              <= '0;
      num_split_r      <= '0;
      wd_cnt           <= '0;
      bus.o_ntt_start  <= 1'b0;
      bus.o_madd_start <= 1'b0;
      bus.o_busy       <= 1'b0;
      bus.o_done       <= 1'b0;
      bus.o_err        <= 1'b0;
    end else begin
      idx              <= idx_nxt;
      wd_cnt           <= in_wait ? wd_cnt + TIMEOUT_W'(1) : '0;
      bus.o_ntt_start  <= ntt_start_d;
      bus.o_madd_start <= madd_start_d;
      bus.o_busy       <= busy_d;
      bus.o_done       <= done_d;
      bus.o_err        <= err_d;
      if (start_acc)
        num_split_r <= (bus.i_num_split > SPLIT_LAST_MAX) ? SPLIT_LAST_MAX : bus.i_num_split;
    end
  end

  assign bus.o_idx_split = idx;

endmodule
